lane_deskew_unstripe: RTL

Receive-side merge block for the two-lane striped link. It accepts words on lane 0 and lane 1, absorbs up to DEPTH words of inter-lane skew in per-lane FIFOs, and re-interleaves them into a single ordered stream: lane 0, lane 1, lane 0, and so on. It sits after the lanes and before the consumer. It is the skew-tolerant counterpart of the stripe transmitter, which places even words on lane 0 and odd words on lane 1.

---
 rtl/lane_deskew_unstripe_if.sv | 38 +++
 rtl/lane_deskew_unstripe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lane_deskew_unstripe_if.sv
// Bus bundle for the two-lane deskew/unstripe merge block.
//
// Handshake: there is no backpressure on either side. A lane word is
// transferred on every rising clk_2f edge where uvalidN=1, and a merged
// word is delivered on every edge where validOut=1; the consumer must
// accept it. A lane word arriving at a full FIFO that is not being popped
// on the same edge is lost and raises skew_err.
interface lane_deskew_unstripe_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         ulane0;
    logic                     uvalid0;
    logic [WIDTH-1:0]         ulane1;
    logic                     uvalid1;
    logic [WIDTH-1:0]         dataOut;
    logic                     validOut;
    logic                     aligned;
    logic                     skew_err;
    // Debug visibility: FSM state and per-lane FIFO occupancy.
    logic [1:0]               dbg_state;
    logic [$clog2(DEPTH):0]   dbg_count0;
    logic [$clog2(DEPTH):0]   dbg_count1;

    // Upstream lanes / downstream consumer side.
    modport master (
        output ulane0, uvalid0, ulane1, uvalid1,
        input  dataOut, validOut, aligned, skew_err,
        input  dbg_state, dbg_count0, dbg_count1
    );

    // Merge block side.
    modport slave (
        input  ulane0, uvalid0, ulane1, uvalid1,
        output dataOut, validOut, aligned, skew_err,
        output dbg_state, dbg_count0, dbg_count1
    );
endinterface

// File: rtl/lane_deskew_unstripe.sv
// Two-lane receive merge: each lane is buffered in its own DEPTH-entry FIFO
// to absorb inter-lane skew, and an FSM re-interleaves the lanes into one
// stream in strict lane0, lane1, lane0, ... order. Lane 0 always leads a
// pair, so after both FIFOs drain at a lane-0 turn the FSM re-aligns in IDLE.
module lane_deskew_unstripe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clk_2f,
    input  logic                 reset,
    lane_deskew_unstripe_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN_L0 = 2'd1,
        S_RUN_L1 = 2'd2
    } state_t;

    // Lane FIFO storage (contents are not reset)
    logic [WIDTH-1:0] r_mem0 [DEPTH];
    logic [WIDTH-1:0] r_mem1 [DEPTH];

    logic [AW-1:0]    r_wp0;
    logic [AW-1:0]    r_rp0;
    logic [CW-1:0]    r_cnt0;
    logic [AW-1:0]    r_wp1;
    logic [AW-1:0]    r_rp1;
    logic [CW-1:0]    r_cnt1;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_pop0;
    logic             w_pop1;

    logic             w_full0;
    logic             w_full1;
    logic             w_wr0;
    logic             w_wr1;
    logic             w_ovf0;
    logic             w_ovf1;

    logic [WIDTH-1:0] r_data_out;
    logic             r_valid_out;
    logic             r_skew_err;

    // A full FIFO still accepts a word if the same edge frees a slot.
    assign w_full0 = (r_cnt0 == CW'(DEPTH));
    assign w_full1 = (r_cnt1 == CW'(DEPTH));
    assign w_wr0   = bus.uvalid0 && (!w_full0 || w_pop0);
    assign w_wr1   = bus.uvalid1 && (!w_full1 || w_pop1);
    assign w_ovf0  = bus.uvalid0 && w_full0 && !w_pop0;
    assign w_ovf1  = bus.uvalid1 && w_full1 && !w_pop1;

    // Lane 0 storage write
    always_ff @(posedge clk_2f) begin
        if (w_wr0) begin
            r_mem0[r_wp0] <= bus.ulane0;
        end
    end

    // Lane 1 storage write
    always_ff @(posedge clk_2f) begin
        if (w_wr1) begin
            r_mem1[r_wp1] <= bus.ulane1;
        end
    end

    // Lane 0 pointers and occupancy; push and pop together leave count as is
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_wp0  <= '0;
            r_rp0  <= '0;
            r_cnt0 <= '0;
        end else begin
            if (w_wr0) begin
                r_wp0 <= r_wp0 + AW'(1);
            end
            if (w_pop0) begin
                r_rp0 <= r_rp0 + AW'(1);
            end
            case ({w_wr0, w_pop0})
                2'b10:   r_cnt0 <= r_cnt0 + CW'(1);
                2'b01:   r_cnt0 <= r_cnt0 - CW'(1);
                default: r_cnt0 <= r_cnt0;
            endcase
        end
    end

    // Lane 1 pointers and occupancy; push and pop together leave count as is
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_wp1  <= '0;
            r_rp1  <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_wr1) begin
                r_wp1 <= r_wp1 + AW'(1);
            end
            if (w_pop1) begin
                r_rp1 <= r_rp1 + AW'(1);
            end
            case ({w_wr1, w_pop1})
                2'b10:   r_cnt1 <= r_cnt1 + CW'(1);
                2'b01:   r_cnt1 <= r_cnt1 - CW'(1);
                default: r_cnt1 <= r_cnt1;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and pop decisions, all from pre-edge FIFO counts
    always_comb begin
        w_next_state = r_state;
        w_pop0       = 1'b0;
        w_pop1       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Only start once a full lane0/lane1 pair can be formed.
                if ((r_cnt0 != '0) && (r_cnt1 != '0)) begin
                    w_pop0       = 1'b1;
                    w_next_state = S_RUN_L1;
                end
            end
            S_RUN_L1: begin
                if (r_cnt1 != '0) begin
                    w_pop1       = 1'b1;
                    w_next_state = S_RUN_L0;
                end
            end
            S_RUN_L0: begin
                if (r_cnt0 != '0) begin
                    w_pop0       = 1'b1;
                    w_next_state = S_RUN_L1;
                end else if (r_cnt1 == '0) begin
                    // Both lanes drained at a pair boundary: re-align.
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Registered merged output; data holds when nothing is popped
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            if (w_pop0) begin
                r_data_out  <= r_mem0[r_rp0];
                r_valid_out <= 1'b1;
            end else if (w_pop1) begin
                r_data_out  <= r_mem1[r_rp1];
                r_valid_out <= 1'b1;
            end else begin
                r_valid_out <= 1'b0;
            end
        end
    end

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_skew_err <= 1'b0;
        end else if (w_ovf0 || w_ovf1) begin
            r_skew_err <= 1'b1;
        end
    end

    assign bus.dataOut    = r_data_out;
    assign bus.validOut   = r_valid_out;
    assign bus.aligned    = (r_state == S_RUN_L0) || (r_state == S_RUN_L1);
    assign bus.skew_err   = r_skew_err;
    assign bus.dbg_state  = r_state;
    assign bus.dbg_count0 = r_cnt0;
    assign bus.dbg_count1 = r_cnt1;

endmodule
